core_ctrl_fsm: RTL and testbench

Multi-cycle sequencer for the RV32I core. It drives fetch, decode, execute, memory and writeback through the instruction decoder and the surrounding datapath. It consumes the decoder's instruction-class summary, raises the decoder enable, issues instruction and data memory handshakes, and steers PC, register-file and CSR writes. It also handles traps, mret/sret, WFI and memory timeouts.

---
 rtl/core_ctrl_pkg.sv | 53 +++++
 rtl/core_ctrl_fsm_if.sv | 24 ++
 rtl/ctrl_timeout_counter.sv | 27 ++
 rtl/core_ctrl_fsm.sv | 191 +++++++++++++++++++
 tb/tb_core_ctrl_fsm.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control sequencer.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6,
        ST_WFI    = 3'd7
    } ctrl_state_e;

    localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
    localparam logic [1:0] PC_SEL_TARGET = 2'd1;
    localparam logic [1:0] PC_SEL_TRAP   = 2'd2;
    localparam logic [1:0] PC_SEL_EPC    = 2'd3;

    localparam logic [3:0] CAUSE_IAF   = 4'd1;
    localparam logic [3:0] CAUSE_ILL   = 4'd2;
    localparam logic [3:0] CAUSE_BRK   = 4'd3;
    localparam logic [3:0] CAUSE_LAF   = 4'd5;
    localparam logic [3:0] CAUSE_SAF   = 4'd7;
    localparam logic [3:0] CAUSE_ECALL = 4'd11;
    localparam logic [3:0] CAUSE_IRQ   = 4'hB;

    typedef struct packed {
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic csr;
        logic ecall;
        logic ebreak;
        logic ret;
        logic wfi;
    } cls_flags_t;

    function automatic logic writes_rd(input cls_flags_t c);
        return !(c.store || c.branch || c.ret || c.wfi);
    endfunction

    function automatic logic [1:0] wb_pc_sel(input cls_flags_t c, input logic taken);
        if (c.ret)
            return PC_SEL_EPC;
        else if (c.jump || (c.branch && taken))
            return PC_SEL_TARGET;
        else
            return PC_SEL_SEQ;
    endfunction

endpackage

// File: rtl/core_ctrl_fsm_if.sv
// Instruction/data memory handshake bundle between the sequencer and the memory side.
interface core_ctrl_fsm_if;
    logic imem_req;
    logic imem_rvalid;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        input  imem_rvalid,
        output dmem_req,
        output dmem_we,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        output imem_rvalid,
        input  dmem_req,
        input  dmem_we,
        output dmem_ready
    );
endinterface

// File: rtl/ctrl_timeout_counter.sv
// Wait-cycle counter for outstanding memory requests; expired flags the edge at which
// the count would reach MEM_TIMEOUT-1.
module ctrl_timeout_counter #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 2);

    logic [CNT_W-1:0] count_reg;

    assign expired = en && (count_reg == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_reg <= '0;
        else if (clr)
            count_reg <= '0;
        else if (en && !expired)
            count_reg <= count_reg + CNT_W'(1);
    end
endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle RV32I sequencer: fetch, decode, execute, memory, writeback, trap and WFI.
module core_ctrl_fsm
    import core_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    core_ctrl_fsm_if.master      mem,
    output logic                 ir_we,
    output logic                 dec_en,
    input  logic                 dec_invalid,
    input  logic                 cls_load,
    input  logic                 cls_store,
    input  logic                 cls_branch,
    input  logic                 cls_jump,
    input  logic                 cls_csr,
    input  logic                 cls_ecall,
    input  logic                 cls_ebreak,
    input  logic                 cls_ret,
    input  logic                 cls_wfi,
    input  logic                 branch_taken,
    input  logic                 irq_pending,
    output logic                 rf_we,
    output logic                 csr_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 trap_enter,
    output logic [3:0]           trap_cause,
    output logic                 trap_return,
    output logic [INSTRET_W-1:0] instret,
    output logic [2:0]           state_dbg
);
    ctrl_state_e            state_reg;
    cls_flags_t             cls_reg;
    cls_flags_t             cls_in;
    logic                   taken_reg;
    logic                   irq_latch_reg;
    logic [3:0]             cause_reg;
    logic [INSTRET_W-1:0]   instret_reg;
    logic                   tmo_en;
    logic                   tmo_expired;
    logic                   fetch_req;
    logic                   data_req;
    logic                   data_we;

    assign cls_in = {cls_load, cls_store, cls_branch, cls_jump, cls_csr,
                     cls_ecall, cls_ebreak, cls_ret, cls_wfi};

    // The counter only runs while a request is outstanding; holding it clear otherwise
    // guarantees it starts from zero on every entry into FETCH or MEM.
    assign tmo_en = ((state_reg == ST_FETCH) && !irq_latch_reg) || (state_reg == ST_MEM);

    ctrl_timeout_counter #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!tmo_en),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cls_reg       <= '0;
            taken_reg     <= 1'b0;
            irq_latch_reg <= 1'b0;
            cause_reg     <= '0;
            instret_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    irq_latch_reg <= irq_pending;
                    state_reg     <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (irq_latch_reg) begin
                        cause_reg <= CAUSE_IRQ;
                        state_reg <= ST_TRAP;
                    end else if (mem.imem_rvalid) begin
                        state_reg <= ST_DECODE;
                    end else if (tmo_expired) begin
                        cause_reg <= CAUSE_IAF;
                        state_reg <= ST_TRAP;
                    end
                end
                ST_DECODE: begin
                    cls_reg <= cls_in;
                    if (dec_invalid) begin
                        cause_reg <= CAUSE_ILL;
                        state_reg <= ST_TRAP;
                    end else begin
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    taken_reg <= branch_taken;
                    if (cls_reg.load || cls_reg.store) begin
                        state_reg <= ST_MEM;
                    end else if (cls_reg.ecall) begin
                        cause_reg <= CAUSE_ECALL;
                        state_reg <= ST_TRAP;
                    end else if (cls_reg.ebreak) begin
                        cause_reg <= CAUSE_BRK;
                        state_reg <= ST_TRAP;
                    end else if (cls_reg.wfi) begin
                        state_reg <= ST_WFI;
                    end else begin
                        instret_reg <= instret_reg + INSTRET_W'(1);
                        state_reg   <= ST_WB;
                    end
                end
                ST_MEM: begin
                    // A response in the expiry cycle still completes normally.
                    if (mem.dmem_ready) begin
                        instret_reg <= instret_reg + INSTRET_W'(1);
                        state_reg   <= ST_WB;
                    end else if (tmo_expired) begin
                        cause_reg <= cls_reg.store ? CAUSE_SAF : CAUSE_LAF;
                        state_reg <= ST_TRAP;
                    end
                end
                ST_WB: begin
                    irq_latch_reg <= irq_pending;
                    state_reg     <= ST_FETCH;
                end
                ST_WFI: begin
                    if (irq_pending) begin
                        instret_reg <= instret_reg + INSTRET_W'(1);
                        state_reg   <= ST_WB;
                    end
                end
                ST_TRAP: begin
                    irq_latch_reg <= irq_pending;
                    state_reg     <= ST_FETCH;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        fetch_req   = 1'b0;
        ir_we       = 1'b0;
        dec_en      = 1'b0;
        data_req    = 1'b0;
        data_we     = 1'b0;
        rf_we       = 1'b0;
        csr_we      = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = PC_SEL_SEQ;
        trap_enter  = 1'b0;
        trap_cause  = 4'd0;
        trap_return = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                fetch_req = !irq_latch_reg;
                ir_we     = !irq_latch_reg && mem.imem_rvalid;
            end
            ST_DECODE, ST_EXEC: dec_en = 1'b1;
            ST_MEM: begin
                data_req = 1'b1;
                data_we  = cls_reg.store;
            end
            ST_WB: begin
                pc_we       = 1'b1;
                rf_we       = writes_rd(cls_reg);
                csr_we      = cls_reg.csr;
                pc_sel      = wb_pc_sel(cls_reg, taken_reg);
                trap_return = cls_reg.ret;
            end
            ST_TRAP: begin
                trap_enter = 1'b1;
                pc_we      = 1'b1;
                pc_sel     = PC_SEL_TRAP;
                trap_cause = cause_reg;
            end
            default: ;
        endcase
    end

    assign mem.imem_req = fetch_req;
    assign mem.dmem_req = data_req;
    assign mem.dmem_we  = data_we;
    assign instret      = instret_reg;
    assign state_dbg    = state_reg;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Directed bench for core_ctrl_fsm: stimulus pushes expected pc_we events, a monitor pops and compares.
module tb_core_ctrl_fsm;
    import core_ctrl_pkg::*;

    localparam int MEM_TIMEOUT = 16;
    localparam logic [8:0] F_NONE   = 9'h000;
    localparam logic [8:0] F_LOAD   = 9'h100;
    localparam logic [8:0] F_STORE  = 9'h080;
    localparam logic [8:0] F_BRANCH = 9'h040;
    localparam logic [8:0] F_JUMP   = 9'h020;
    localparam logic [8:0] F_CSR    = 9'h010;
    localparam logic [8:0] F_ECALL  = 9'h008;
    localparam logic [8:0] F_EBREAK = 9'h004;
    localparam logic [8:0] F_RET    = 9'h002;
    localparam logic [8:0] F_WFI    = 9'h001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ir_we, dec_en, dec_invalid, branch_taken, irq_pending;
    logic        rf_we, csr_we, pc_we, trap_enter, trap_return;
    logic [1:0]  pc_sel;
    logic [3:0]  trap_cause;
    logic [31:0] instret;
    logic [2:0]  state_dbg;
    logic [8:0]  cls_drv;
    logic [18:0] outs_vec;

    typedef struct {
        string       name;
        logic [41:0] vec;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [41:0] mon_got;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_instret = 0;

    always #5 clk = ~clk;

    core_ctrl_fsm_if mem_if();

    core_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .INSTRET_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem          (mem_if.master),
        .ir_we        (ir_we),
        .dec_en       (dec_en),
        .dec_invalid  (dec_invalid),
        .cls_load     (cls_drv[8]),
        .cls_store    (cls_drv[7]),
        .cls_branch   (cls_drv[6]),
        .cls_jump     (cls_drv[5]),
        .cls_csr      (cls_drv[4]),
        .cls_ecall    (cls_drv[3]),
        .cls_ebreak   (cls_drv[2]),
        .cls_ret      (cls_drv[1]),
        .cls_wfi      (cls_drv[0]),
        .branch_taken (branch_taken),
        .irq_pending  (irq_pending),
        .rf_we        (rf_we),
        .csr_we       (csr_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .trap_enter   (trap_enter),
        .trap_cause   (trap_cause),
        .trap_return  (trap_return),
        .instret      (instret),
        .state_dbg    (state_dbg)
    );

    assign outs_vec = {mem_if.imem_req, ir_we, dec_en, mem_if.dmem_req, mem_if.dmem_we,
                       rf_we, csr_we, pc_we, pc_sel, trap_enter, trap_cause, trap_return, state_dbg};

    // Monitor: every PC update is a retire or trap event and must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && pc_we) begin
            mon_got = {rf_we, csr_we, pc_sel, trap_enter, trap_cause, trap_return, instret};
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pc_we: got %h required no event", mon_got);
            end else begin
                mon_e = sb.pop_front();
                if (mon_got !== mon_e.vec) begin
                    n_bad++;
                    $display("FAIL %s: got %h required %h", mon_e.name, mon_got, mon_e.vec);
                end else begin
                    $display("event %s ok: %h", mon_e.name, mon_got);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, req);
        end
    endtask

    task automatic push(input string nm, input logic rf, input logic csr, input logic [1:0] sel,
                        input logic te, input logic [3:0] cause, input logic tr, input int ir);
        exp_t e;
        e.name = nm;
        e.vec  = {rf, csr, sel, te, cause, tr, 32'(ir)};
        sb.push_back(e);
    endtask

    task automatic do_fetch(input string nm, input int wait_n);
        chk({nm, ":fetch_state"}, 32'(state_dbg), 32'(ST_FETCH));
        chk({nm, ":imem_req"}, 32'(mem_if.imem_req), 32'd1);
        repeat (wait_n) tick();
        mem_if.imem_rvalid = 1'b1;
        #1;
        chk({nm, ":ir_we"}, 32'(ir_we), 32'd1);
        tick();
        mem_if.imem_rvalid = 1'b0;
        chk({nm, ":decode_state"}, 32'(state_dbg), 32'(ST_DECODE));
    endtask

    task automatic do_decode(input string nm, input logic [8:0] flags, input logic inv, input ctrl_state_e nxt);
        cls_drv     = flags;
        dec_invalid = inv;
        #1;
        chk({nm, ":dec_en"}, 32'(dec_en), 32'd1);
        tick();
        cls_drv     = F_NONE;
        dec_invalid = 1'b0;
        chk({nm, ":after_decode"}, 32'(state_dbg), 32'(nxt));
    endtask

    task automatic do_exec(input string nm, input logic taken, input ctrl_state_e nxt);
        branch_taken = taken;
        tick();
        branch_taken = 1'b0;
        chk({nm, ":after_exec"}, 32'(state_dbg), 32'(nxt));
    endtask

    task automatic run_simple(input string nm, input int fwait, input logic [8:0] flags, input logic taken,
                              input logic rf, input logic csr, input logic [1:0] sel, input logic tr);
        $display("txn %s", nm);
        do_fetch(nm, fwait);
        do_decode(nm, flags, 1'b0, ST_EXEC);
        exp_instret++;
        push(nm, rf, csr, sel, 1'b0, 4'd0, tr, exp_instret);
        do_exec(nm, taken, ST_WB);
        tick();
        chk({nm, ":back_to_fetch"}, 32'(state_dbg), 32'(ST_FETCH));
    endtask

    task automatic run_mem(input string nm, input logic [8:0] flags, input int wait_n, input logic store);
        $display("txn %s", nm);
        do_fetch(nm, 0);
        do_decode(nm, flags, 1'b0, ST_EXEC);
        exp_instret++;
        push(nm, !store, 1'b0, PC_SEL_SEQ, 1'b0, 4'd0, 1'b0, exp_instret);
        do_exec(nm, 1'b0, ST_MEM);
        chk({nm, ":dmem_req"}, 32'(mem_if.dmem_req), 32'd1);
        chk({nm, ":dmem_we"}, 32'(mem_if.dmem_we), 32'(store));
        repeat (wait_n) tick();
        chk({nm, ":still_mem"}, 32'(state_dbg), 32'(ST_MEM));
        mem_if.dmem_ready = 1'b1;
        tick();
        mem_if.dmem_ready = 1'b0;
        chk({nm, ":wb_state"}, 32'(state_dbg), 32'(ST_WB));
        tick();
        chk({nm, ":back_to_fetch"}, 32'(state_dbg), 32'(ST_FETCH));
    endtask

    task automatic run_exec_trap(input string nm, input logic [8:0] flags, input logic [3:0] cause);
        $display("txn %s", nm);
        do_fetch(nm, 0);
        do_decode(nm, flags, 1'b0, ST_EXEC);
        push(nm, 1'b0, 1'b0, PC_SEL_TRAP, 1'b1, cause, 1'b0, exp_instret);
        do_exec(nm, 1'b0, ST_TRAP);
        tick();
        chk({nm, ":back_to_fetch"}, 32'(state_dbg), 32'(ST_FETCH));
    endtask

    initial begin
        int   n;
        logic rf_seen;
        logic [15:0] idle_or;

        rst_n              = 1'b0;
        mem_if.imem_rvalid = 1'b0;
        mem_if.dmem_ready  = 1'b0;
        dec_invalid        = 1'b0;
        branch_taken       = 1'b0;
        irq_pending        = 1'b0;
        cls_drv            = F_NONE;

        $display("txn reset");
        repeat (2) tick();
        chk("reset_outputs", 32'(outs_vec), 32'd0);
        chk("reset_instret", instret, 32'd0);
        rst_n = 1'b1;
        chk("idle_after_release", 32'(state_dbg), 32'(ST_IDLE));
        tick();
        chk("fetch_after_idle", 32'(state_dbg), 32'(ST_FETCH));

        run_simple("addi",      1, F_NONE,   1'b0, 1'b1, 1'b0, PC_SEL_SEQ,    1'b0);
        run_simple("beq_taken", 0, F_BRANCH, 1'b1, 1'b0, 1'b0, PC_SEL_TARGET, 1'b0);
        run_simple("beq_not",   0, F_BRANCH, 1'b0, 1'b0, 1'b0, PC_SEL_SEQ,    1'b0);
        run_simple("jal",       0, F_JUMP,   1'b0, 1'b1, 1'b0, PC_SEL_TARGET, 1'b0);
        run_simple("csrrw",     0, F_CSR,    1'b0, 1'b1, 1'b1, PC_SEL_SEQ,    1'b0);
        run_mem("load_wait2", F_LOAD, 2, 1'b0);
        run_mem("store_now", F_STORE, 0, 1'b1);

        $display("txn load_timeout");
        do_fetch("load_tmo", 0);
        do_decode("load_tmo", F_LOAD, 1'b0, ST_EXEC);
        push("load_tmo", 1'b0, 1'b0, PC_SEL_TRAP, 1'b1, 4'd5, 1'b0, exp_instret);
        do_exec("load_tmo", 1'b0, ST_MEM);
        n = 0;
        rf_seen = 1'b0;
        while (state_dbg == ST_MEM && n < 30) begin
            n++;
            rf_seen |= rf_we;
            tick();
        end
        chk("load_tmo:mem_cycles", 32'(n), 32'(MEM_TIMEOUT - 1));
        chk("load_tmo:trap_state", 32'(state_dbg), 32'(ST_TRAP));
        chk("load_tmo:no_rf_we", 32'(rf_seen), 32'd0);
        tick();
        chk("load_tmo:back_to_fetch", 32'(state_dbg), 32'(ST_FETCH));

        run_mem("store_race", F_STORE, MEM_TIMEOUT - 2, 1'b1);

        $display("txn fetch_timeout");
        push("fetch_tmo", 1'b0, 1'b0, PC_SEL_TRAP, 1'b1, 4'd1, 1'b0, exp_instret);
        n = 0;
        while (state_dbg == ST_FETCH && n < 40) begin
            n++;
            tick();
        end
        chk("fetch_tmo:cycles", 32'(n), 32'(MEM_TIMEOUT - 1));
        chk("fetch_tmo:trap_state", 32'(state_dbg), 32'(ST_TRAP));
        tick();

        $display("txn dec_invalid");
        do_fetch("illegal", 0);
        push("illegal", 1'b0, 1'b0, PC_SEL_TRAP, 1'b1, 4'd2, 1'b0, exp_instret);
        do_decode("illegal", F_NONE, 1'b1, ST_TRAP);
        tick();

        run_exec_trap("ecall", F_ECALL, 4'd11);
        run_exec_trap("ebreak", F_EBREAK, 4'd3);
        run_simple("mret", 0, F_RET, 1'b0, 1'b0, 1'b0, PC_SEL_EPC, 1'b1);

        $display("txn wfi_irq");
        do_fetch("wfi", 0);
        do_decode("wfi", F_WFI, 1'b0, ST_EXEC);
        do_exec("wfi", 1'b0, ST_WFI);
        n = 0;
        idle_or = '0;
        for (int i = 0; i < 10; i++) begin
            if (state_dbg == ST_WFI) n++;
            if (i == 9) begin
                irq_pending = 1'b1;
                #1;
                exp_instret++;
                push("wfi_retire", 1'b0, 1'b0, PC_SEL_SEQ, 1'b0, 4'd0, 1'b0, exp_instret);
            end
            idle_or |= outs_vec[18:3];
            tick();
        end
        chk("wfi:cycles", 32'(n), 32'd10);
        chk("wfi:outputs_idle", 32'(idle_or), 32'd0);
        chk("wfi:wb_state", 32'(state_dbg), 32'(ST_WB));
        tick();
        chk("wfi:fetch_state", 32'(state_dbg), 32'(ST_FETCH));
        chk("wfi:no_imem_req", 32'(mem_if.imem_req), 32'd0);
        push("irq_trap", 1'b0, 1'b0, PC_SEL_TRAP, 1'b1, 4'hB, 1'b0, exp_instret);
        irq_pending = 1'b0;
        tick();
        chk("irq:trap_state", 32'(state_dbg), 32'(ST_TRAP));
        tick();
        chk("irq:refetch_req", 32'(mem_if.imem_req), 32'd1);

        $display("txn reset_mid_mem");
        do_fetch("rst_mem", 0);
        do_decode("rst_mem", F_LOAD, 1'b0, ST_EXEC);
        do_exec("rst_mem", 1'b0, ST_MEM);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mem:outputs", 32'(outs_vec), 32'd0);
        chk("rst_mem:instret", instret, 32'd0);
        tick();
        rst_n = 1'b1;
        exp_instret = 0;
        chk("rst_mem:idle", 32'(state_dbg), 32'(ST_IDLE));
        tick();
        chk("rst_mem:fetch", 32'(state_dbg), 32'(ST_FETCH));
        run_simple("addi_after_reset", 0, F_NONE, 1'b0, 1'b1, 1'b0, PC_SEL_SEQ, 1'b0);

        tick();
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
